sobel_window_gen: RTL and testbench

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

---
 rtl/sobel_pkg.sv | 10 +
 rtl/sobel_line_buf.sv | 36 +++
 rtl/sobel_window_gen.sv | 130 +++++++++++++
 tb/tb_sobel_window_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants and pixel type for the Sobel window generator.
package sobel_pkg;

    localparam int PIX_W     = 8;
    localparam int IMG_W_DEF = 64;
    localparam int IMG_H_DEF = 64;

    typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/sobel_line_buf.sv
// One line of pixel delay: dout is the pixel written DEPTH enables earlier.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  pix_t din,
    output pix_t dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pix_t           mem [DEPTH];
    logic [AW-1:0]  ptr;

    // Circular buffer: the slot about to be overwritten holds the oldest pixel.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// 3x3 raster window generator for Sobel filtering.
// Optional window-centre coordinates are enabled with macro SOBEL_WIN_COORD_EN.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  pix_t                     pix_in,
    input  logic                     pix_valid,
    input  logic                     sof,
    output pix_t                     p0,
    output pix_t                     p1,
    output pix_t                     p2,
    output pix_t                     p3,
    output pix_t                     p4,
    output pix_t                     p5,
    output pix_t                     p6,
    output pix_t                     p7,
    output pix_t                     p8,
    output logic                     win_valid,
`ifdef SOBEL_WIN_COORD_EN
    output logic [$clog2(IMG_W)-1:0] win_x,
    output logic [$clog2(IMG_H)-1:0] win_y,
`endif
    output logic                     frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col;
    logic [CW-1:0] eff_col;
    logic [RW-1:0] row;
    logic [RW-1:0] eff_row;
    logic          last_col;
    logic          last_row;
    pix_t          lb1_out;
    pix_t          lb2_out;
    pix_t          win [9];

    // sof re-anchors the accepted pixel itself at (0,0).
    always_comb begin
        eff_col  = sof ? '0 : col;
        eff_row  = sof ? '0 : row;
        last_col = (eff_col == CW'(IMG_W - 1));
        last_row = (eff_row == RW'(IMG_H - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : eff_row + 1'b1;
            end else begin
                col <= eff_col + 1'b1;
                row <= eff_row;
            end
        end
    end

    sobel_line_buf #(.DEPTH(IMG_W)) u_lb1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_valid),
        .din   (pix_in),
        .dout  (lb1_out)
    );

    sobel_line_buf #(.DEPTH(IMG_W)) u_lb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_valid),
        .din   (lb1_out),
        .dout  (lb2_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= pix_valid && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
            frame_done <= pix_valid && last_col && last_row;
            if (pix_valid) begin
                // Each row shifts left; the new right column is {r-2, r-1, r}.
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= lb2_out;
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= lb1_out;
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= pix_in;
            end
        end
    end

`ifdef SOBEL_WIN_COORD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_x <= '0;
            win_y <= '0;
        end else if (pix_valid) begin
            win_x <= eff_col - 1'b1;
            win_y <= eff_row - 1'b1;
        end
    end
`endif

    assign p0 = win[0];
    assign p1 = win[1];
    assign p2 = win[2];
    assign p3 = win[3];
    assign p4 = win[4];
    assign p5 = win[5];
    assign p6 = win[6];
    assign p7 = win[7];
    assign p8 = win[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 4x4 frame with pixel = 16*row+col.
module tb_sobel_window_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int EW = 76;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] pix_in = 8'h00;
    logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic       win_valid;
    logic       frame_done;
`ifdef SOBEL_WIN_COORD_EN
    logic [1:0] win_x;
    logic [1:0] win_y;
`endif

    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .p0         (p0),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p4         (p4),
        .p5         (p5),
        .p6         (p6),
        .p7         (p7),
        .p8         (p8),
        .win_valid  (win_valid),
`ifdef SOBEL_WIN_COORD_EN
        .win_x      (win_x),
        .win_y      (win_y),
`endif
        .frame_done (frame_done)
    );

    logic [EW-1:0] exp_q[$];
    int            n_tests = 0;
    int            n_fail = 0;
    int            win_seen = 0;
    bit            mon_en = 1'b0;
    logic          cur_last = 1'b0;
    logic          acc_q;
    logic          fd_exp;
    logic [7:0]    hist1;
    logic [7:0]    hist2;

    function automatic logic [EW-1:0] exp_win(input int r, input int c);
        logic [71:0] w;
        logic [3:0]  cd;
        int          rr;
        int          cc;
        w = '0;
        for (int i = 0; i < 9; i++) begin
            rr = r - 2 + i / 3;
            cc = c - 2 + i % 3;
            w  = {w[63:0], 8'(16 * rr + cc)};
        end
`ifdef SOBEL_WIN_COORD_EN
        cd = {2'(c - 1), 2'(r - 1)};
`else
        cd = 4'h0;
`endif
        return {w, cd};
    endfunction

    function automatic logic [EW-1:0] act_win();
        logic [3:0] cd;
`ifdef SOBEL_WIN_COORD_EN
        cd = {win_x, win_y};
`else
        cd = 4'h0;
`endif
        return {p0, p1, p2, p3, p4, p5, p6, p7, p8, cd};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference record of what was accepted, built from the bench's own drive.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= 1'b0;
            fd_exp <= 1'b0;
            hist1  <= 8'h00;
            hist2  <= 8'h00;
        end else begin
            acc_q  <= pix_valid;
            fd_exp <= pix_valid && cur_last;
            if (pix_valid) begin
                hist2 <= hist1;
                hist1 <= pix_in;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("frame_done", EW'(frame_done), EW'(fd_exp));
            if (win_valid) begin
                win_seen++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_window: got %h expected no window", act_win());
                end else begin
                    check("window", act_win(), exp_q.pop_front());
                end
            end
            if (!acc_q) begin
                check("gap_win_valid", EW'(win_valid), '0);
                check("gap_hold", EW'({p7, p8}), EW'({hist2, hist1}));
            end
        end
    end

    task automatic send(input int r, input int c, input bit s, input int gap);
        if (gap > 0) begin
            pix_valid = 1'b0;
            sof       = 1'b0;
            pix_in    = 8'hEE;
            repeat (gap) @(posedge clk);
            #1;
        end
        pix_valid = 1'b1;
        sof       = s;
        pix_in    = 8'(16 * r + c);
        cur_last  = (r == H - 1) && (c == W - 1);
        if (r >= 2 && c >= 2) exp_q.push_back(exp_win(r, c));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        sof       = 1'b0;
        pix_in    = 8'hEE;
        cur_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit first_sof, input int max_gap);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send(r, c, first_sof && r == 0 && c == 0, $urandom_range(0, max_gap));
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_window", act_win(), '0);
        check("reset_flags", EW'({win_valid, frame_done}), '0);
        #3;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Continuous frame.
        send_frame(1'b1, 0);
        idle(4);

        // Same frame with idle gaps between pixels.
        send_frame(1'b0, 3);
        idle(4);

        // Partial frame, then sof restarts at what was row 1 col 1.
        send(0, 0, 1'b1, 0);
        send(0, 1, 1'b0, 0);
        send(0, 2, 1'b0, 0);
        send(0, 3, 1'b0, 0);
        send(1, 0, 1'b0, 0);
        send_frame(1'b1, 0);
        idle(4);

        // Reset in the middle of row 2, then a frame with no sof.
        for (int i = 0; i < 10; i++) begin
            send(i / W, i % W, i == 0, 0);
        end
        pix_valid = 1'b0;
        pix_in    = 8'hEE;
        cur_last  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_window", act_win(), '0);
        check("midreset_flags", EW'({win_valid, frame_done}), '0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(1'b0, 0);
        idle(4);

        check("queue_empty", EW'(exp_q.size()), '0);
        check("window_count", EW'(win_seen), EW'(16));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
